note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Bus-slave/bus-master scheduler for the audio datapath (square1/2, sawtooth, triangle -> mixer -> DAC).
//  CPU pushes timed note events into an internal FIFO; block pops them, writes each period value to the
//  target oscillator's register over its master port, then holds for the event duration in ticks.
//  Frees the CPU from per-note timing; sits at slave select mem_addr[31:24]==8'h0F.
// PARAMETERS
//  FIFO_DEPTH   16            event FIFO entries, power of 2 (>=2)
//  CH0_ADDR     32'h0700_0000 period register address, channel 0 (square1)
//  CH1_ADDR     32'h0800_0000 channel 1 (square2)
//  CH2_ADDR     32'h0A00_0000 channel 2 (sawtooth)
//  CH3_ADDR     32'h0B00_0000 channel 3 (triangle)
// PORTS
//  clk      in   1   system clock; single clock domain
//  reset    in   1   synchronous, active-high reset
//  valid    in   1   slave request (already qualified by select)
//  ready    out  1   slave ack
//  wstrb    in   4   slave byte strobes; 0 = read
//  addr     in   32  slave address; only addr[3:2] decoded
//  wdata    in   32  slave write data
//  rdata    out  32  slave read data
//  m_valid  out  1   master write request to oscillator
//  m_ready  in   1   master ack from oscillator
//  m_addr   out  32  master address (CHn_ADDR)
//  m_wdata  out  32  master data {16'h0, period}
//  m_wstrb  out  4   4'b1111 while m_valid, else 0
// BEHAVIOUR
//  Reset: ready=0, rdata=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0; FIFO empty, CTRL=0, DIV=0,
//   overflow=0, state IDLE. Reset mid-operation aborts everything, incl. an m_valid in flight.
//  Slave: ready pulses high exactly 1 cycle, the cycle after valid first seen; rdata valid with ready.
//   Side effects (push, clear) occur once per access. Registers (addr[3:2]):
//   0 CTRL  RW bit0 EN; bit1 CLR (write-1 self-clearing: empties FIFO, clears overflow)
//   1 STAT  RO [7:0] count, [8] empty, [9] full, [10] busy (state!=IDLE), [11] overflow (sticky)
//   2 PUSH  WO event {ch[31:30], dur[29:16], period[15:0]}; reads return 0
//   3 DIV   RW [23:0] clk cycles per tick minus 1
//  Push when full: dropped, overflow<=1. Push and pop same cycle: both occur, count unchanged.
//  Tick: 24-bit counter runs while state==WAIT; tick when counter==DIV, then counter<=0.
//  FSM:
//   IDLE : if EN && !empty -> FETCH
//   FETCH: pop head; latch ch/dur/period; m_addr<=CHn_ADDR, m_wdata<={16'h0,period}; -> WRITE
//   WRITE: m_valid=1 held until m_ready sampled high; then m_valid<=0 next cycle;
//          if dur==0 -> IDLE, else load remaining=dur, tick counter<=0 -> WAIT
//   WAIT : on tick remaining-=1; when remaining hits 0 -> IDLE (next event fetched next cycle)
//  EN cleared: WRITE never aborted (completes handshake); WAIT stops counting and holds;
//   FETCH/IDLE do not pop. Setting EN resumes where held.
//  CLR during WAIT/WRITE: FIFO emptied, current event finishes normally.
//  Event latency from push (EN=1, idle, empty FIFO): m_valid high 3 cycles after push ready.
//  Total note time = (dur*(DIV+1)) clk cycles measured from m_ready to next FETCH, ±1 cycle.
// TESTING
//  1 Reset: assert reset 2 cycles mid-WAIT -> all outputs 0, STAT reads 0x100 (empty).
//  2 DIV=9, EN=1, push {ch=1,dur=3,period=0x1234}, m_ready 1 cycle after m_valid
//    -> one write m_addr=0x0800_0000 m_wdata=0x0000_1234; busy clears 30 clk after m_ready.
//  3 Push 17 events with EN=0 (depth 16) -> STAT count=16, full=1, overflow=1; CLR -> STAT=0x100.
//  4 Back-to-back events dur=0 on ch0..ch3, m_ready delayed 5 cycles -> 4 writes in order,
//    addresses CH0..CH3, m_valid held stable (addr/data unchanged) until each m_ready.
//  5 Clear EN during WAIT for 50 cycles then set -> remaining duration resumes, no write lost/dup.
//  6 Push same cycle as internal pop with FIFO full -> count stays 16, overflow stays 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Timed note-event scheduler: CPU pushes {ch, dur, period} events into a FIFO, the block writes each
// period to the selected oscillator over its master port, then holds for dur ticks of (DIV+1) clocks.
module note_sequencer #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] CH0_ADDR   = 32'h0700_0000,
  parameter logic [31:0] CH1_ADDR   = 32'h0800_0000,
  parameter logic [31:0] CH2_ADDR   = 32'h0A00_0000,
  parameter logic [31:0] CH3_ADDR   = 32'h0B00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_WAIT} state_t;
  typedef enum logic [1:0] {R_CTRL, R_STAT, R_PUSH, R_DIV} reg_t;

  state_t state, state_nxt;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, overflow, en, busy;
  logic [23:0]   div, tick_cnt;
  logic [13:0]   cur_dur, remaining;
  logic [31:0]   head, rd_mux;
  reg_t          sel;
  logic          access, wr, push_req, push_ok, clr, pop, tick, hs;
  logic          unused_addr_bits;

  function automatic logic [31:0] ch_addr(input logic [1:0] ch);
    case (ch)
      2'd0:    return CH0_ADDR;
      2'd1:    return CH1_ADDR;
      2'd2:    return CH2_ADDR;
      default: return CH3_ADDR;
    endcase
  endfunction

  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  assign sel      = reg_t'(addr[3:2]);
  assign access   = valid && !ready;          // first cycle of an access only
  assign wr       = access && (wstrb != 4'b0000);
  assign push_req = wr && (sel == R_PUSH);
  assign clr      = wr && (sel == R_CTRL) && wdata[1];
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign busy     = (state != S_IDLE);
  assign head     = fifo_mem[rd_ptr];
  assign pop      = (state == S_FETCH) && en && !empty;
  assign push_ok  = push_req && (!full || pop);
  assign tick     = (state == S_WAIT) && en && (tick_cnt == div);
  assign hs       = m_valid && m_ready;
  assign m_wstrb  = {4{m_valid}};

  always_comb begin
    rd_mux = '0;
    case (sel)
      R_CTRL:  rd_mux = {31'h0, en};
      R_STAT:  rd_mux = {20'h0, overflow, busy, full, empty, 8'(count)};
      R_PUSH:  rd_mux = '0;
      R_DIV:   rd_mux = {8'h0, div};
      default: rd_mux = '0;
    endcase
  end

  // Slave side: one-cycle ready pulse, registers updated on the first cycle of the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
      rdata <= '0;
      en    <= 1'b0;
      div   <= '0;
    end else begin
      ready <= access;
      rdata <= access ? rd_mux : '0;
      if (wr && sel == R_CTRL) en  <= wdata[0];
      if (wr && sel == R_DIV)  div <= wdata[23:0];
    end
  end

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state defaults to current state first so no path leaves it unassigned.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en && !empty) state_nxt = S_FETCH;
      S_FETCH: begin
        if (pop)        state_nxt = S_WRITE;
        else if (empty) state_nxt = S_IDLE;
      end
      S_WRITE: if (hs) state_nxt = (cur_dur == '0) ? S_IDLE : S_WAIT;
      S_WAIT:  if (tick && remaining == 14'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Master datapath; m_valid rises one cycle into WRITE and drops after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      cur_dur   <= '0;
      remaining <= '0;
      tick_cnt  <= '0;
    end else begin
      case (state)
        S_FETCH: if (pop) begin
          cur_dur <= head[29:16];
          m_addr  <= ch_addr(head[31:30]);
          m_wdata <= {16'h0, head[15:0]};
        end
        S_WRITE: begin
          if (hs) begin
            m_valid   <= 1'b0;
            remaining <= cur_dur;
            tick_cnt  <= '0;
          end else begin
            m_valid <= 1'b1;
          end
        end
        S_WAIT: if (en) begin
          if (tick) begin
            tick_cnt  <= '0;
            remaining <= remaining - 14'd1;
          end else begin
            tick_cnt <= tick_cnt + 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: bus tasks, an m_ready responder/monitor and a timing model
// of note events (order, addresses, data, and write-to-write spacing dur*(DIV+1)+3).
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_delay = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          rise;
    int          hs;
  } wr_t;
  wr_t obs[$];

  note_sequencer dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] exp_addr(input int ch);
    case (ch)
      0:       return 32'h0700_0000;
      1:       return 32'h0800_0000;
      2:       return 32'h0A00_0000;
      default: return 32'h0B00_0000;
    endcase
  endfunction

  // Oscillator-side responder: acks after ready_delay cycles, records each write, checks hold stability.
  int          wait_cnt = 0;
  int          cur_rise = 0;
  logic        prev_mv = 1'b0;
  logic [31:0] hold_a, hold_d;
  always @(negedge clk) begin
    if (reset) begin
      m_ready  = 1'b0;
      wait_cnt = 0;
      prev_mv  = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b0;
      prev_mv = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL m_valid_after_ack: m_valid=%b expected 0", m_valid);
      end
    end else if (m_valid) begin
      if (!prev_mv) begin
        cur_rise = cyc;
        hold_a   = m_addr;
        hold_d   = m_wdata;
      end else begin
        checks++;
        if ({m_addr, m_wdata} !== {hold_a, hold_d}) begin
          errors++;
          $display("FAIL m_hold_stable: addr=%h data=%h expected addr=%h data=%h",
                   m_addr, m_wdata, hold_a, hold_d);
        end
      end
      prev_mv = 1'b1;
      if (wait_cnt >= ready_delay) begin
        m_ready = 1'b1;
        obs.push_back('{a: m_addr, d: m_wdata, s: m_wstrb, rise: cur_rise, hs: cyc + 1});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      if (prev_mv) begin
        checks++;
        errors++;
        $display("FAIL m_valid_dropped: m_valid=0 before m_ready, expected held");
      end
      prev_mv = 1'b0;
    end
  end

  task automatic do_reset();
    valid = 1'b0;
    wstrb = 4'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_access(input logic [1:0] r, input logic [3:0] strb, input logic [31:0] d,
                            output logic [31:0] rd, output int eff);
    @(negedge clk);
    valid = 1'b1;
    addr  = {24'h0F_0000, 4'h0, r, 2'b00};
    wstrb = strb;
    wdata = d;
    @(negedge clk);
    eff = cyc;
    rd  = rdata;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_ready: ready=%b expected 1 (reg %0d)", ready, r);
    end
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic reg_write(input logic [1:0] r, input logic [31:0] d, output int eff);
    logic [31:0] rd;
    bus_access(r, 4'hF, d, rd, eff);
  endtask

  task automatic reg_read(input logic [1:0] r, output logic [31:0] rd, output int eff);
    bus_access(r, 4'h0, 32'h0, rd, eff);
  endtask

  task automatic push_ev(input int ch, input int dur, input logic [15:0] period, output int eff);
    logic [1:0]  c = 2'(ch);
    logic [13:0] du = 14'(dur);
    reg_write(2'd2, {c, du, period}, eff);
  endtask

  task automatic expect_reg(input string name, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] rd;
    int e;
    reg_read(r, rd, e);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s: read %h expected %h", name, rd, exp);
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (obs.size() < n) begin
      errors++;
      $display("FAIL write_timeout: saw %0d writes expected %0d", obs.size(), n);
    end
  endtask

  task automatic check_write(input string name, input int idx, input int ch, input logic [15:0] p);
    checks++;
    if (obs.size() <= idx) begin
      errors++;
      $display("FAIL %s: write %0d missing", name, idx);
    end else if ({obs[idx].a, obs[idx].d, obs[idx].s} !== {exp_addr(ch), 16'h0, p, 4'hF}) begin
      errors++;
      $display("FAIL %s: write %0d addr=%h data=%h strb=%h expected addr=%h data=%h strb=f",
               name, idx, obs[idx].a, obs[idx].d, obs[idx].s, exp_addr(ch), {16'h0, p});
    end
  endtask

  task automatic check_gap(input string name, input int idx, input int exp);
    int gap;
    checks++;
    if (obs.size() <= idx + 1) begin
      errors++;
      $display("FAIL %s: write %0d missing for spacing", name, idx + 1);
    end else begin
      gap = obs[idx + 1].rise - obs[idx].hs;
      if (gap < exp - 1 || gap > exp + 1) begin
        errors++;
        $display("FAIL %s: spacing after write %0d is %0d expected %0d +-1", name, idx, gap, exp);
      end
    end
  endtask

  task automatic test_reset();
    int e;
    do_reset();
    obs.delete();
    ready_delay = 0;
    reg_write(2'd3, 32'd3, e);
    push_ev(0, 200, 16'h0AAA, e);
    push_ev(1, 5, 16'h0BBB, e);
    reg_write(2'd0, 32'd1, e);
    wait_writes(1, 50);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, rdata, m_valid, m_addr, m_wdata, m_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h m_valid=%b m_addr=%h m_wdata=%h m_wstrb=%h expected all 0",
               ready, rdata, m_valid, m_addr, m_wdata, m_wstrb);
    end
    reset = 1'b0;
    obs.delete();
    repeat (30) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL reset_abort: %0d writes after reset expected 0", obs.size());
    end
    expect_reg("reset_stat", 2'd1, 32'h100);
    expect_reg("reset_ctrl", 2'd0, 32'h0);
    expect_reg("reset_div", 2'd3, 32'h0);
  endtask

  task automatic test_single_note();
    int e_push, e;
    int h;
    logic [31:0] rd;
    do_reset();
    obs.delete();
    ready_delay = 1;
    reg_write(2'd3, 32'd9, e);
    reg_write(2'd0, 32'd1, e);
    push_ev(1, 3, 16'h1234, e_push);
    wait_writes(1, 100);
    check_write("single_write", 0, 1, 16'h1234);
    if (obs.size() > 0) begin
      checks++;
      if (obs[0].rise - e_push != 3) begin
        errors++;
        $display("FAIL single_latency: m_valid %0d cycles after push expected 3", obs[0].rise - e_push);
      end
      h = obs[0].hs;
      rd = 32'hFFFF_FFFF;
      for (int k = 0; k < 40 && rd[10] !== 1'b0; k++) reg_read(2'd1, rd, e);
      checks++;
      if (rd[10] !== 1'b0 || (e - 1 - h) < 29 || (e - 1 - h) > 32) begin
        errors++;
        $display("FAIL single_busy_time: busy=%b cleared %0d cycles after m_ready expected 30",
                 rd[10], e - 1 - h);
      end
    end
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL single_count: %0d writes expected 1", obs.size());
    end
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    for (int i = 0; i < 17; i++) push_ev(i % 4, i, 16'(i * 7), e);
    expect_reg("overflow_stat", 2'd1, 32'h0A10);
    reg_write(2'd0, 32'd2, e);
    expect_reg("clr_stat", 2'd1, 32'h100);
    expect_reg("clr_ctrl", 2'd0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int e;
    logic [15:0] p[4];
    do_reset();
    ready_delay = 5;
    for (int i = 0; i < 4; i++) begin
      p[i] = 16'($urandom);
      push_ev(i, 0, p[i], e);
    end
    obs.delete();
    reg_write(2'd0, 32'd1, e);
    wait_writes(4, 300);
    for (int i = 0; i < 4; i++) check_write("b2b_write", i, i, p[i]);
    for (int i = 0; i < 3; i++) check_gap("b2b_gap", i, 3);
  endtask

  task automatic test_pause();
    int e, ea, eb;
    do_reset();
    ready_delay = 0;
    reg_write(2'd3, 32'd9, e);
    push_ev(2, 3, 16'h5555, e);
    push_ev(3, 0, 16'h6666, e);
    obs.delete();
    reg_write(2'd0, 32'd1, e);
    wait_writes(1, 50);
    repeat (5) @(negedge clk);
    reg_write(2'd0, 32'd0, ea);
    expect_reg("pause_stat", 2'd1, 32'h401);
    repeat (46) @(negedge clk);
    reg_write(2'd0, 32'd1, eb);
    wait_writes(2, 300);
    check_write("pause_first", 0, 2, 16'h5555);
    check_write("pause_second", 1, 3, 16'h6666);
    check_gap("pause_gap", 0, 33 + (eb - ea));
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != 2) begin
      errors++;
      $display("FAIL pause_count: %0d writes expected 2", obs.size());
    end
  endtask

  task automatic test_push_pop_full();
    int e;
    logic [15:0] p0;
    do_reset();
    ready_delay = 0;
    reg_write(2'd3, 32'd9, e);
    p0 = 16'($urandom);
    push_ev(1, 50, p0, e);
    for (int i = 1; i < 16; i++) push_ev(i % 4, 50, 16'(i), e);
    obs.delete();
    reg_write(2'd0, 32'd1, e);
    push_ev(0, 50, 16'hBEEF, e);
    expect_reg("pushpop_stat", 2'd1, 32'h0610);
    wait_writes(1, 50);
    check_write("pushpop_first", 0, 1, p0);
  endtask

  task automatic test_random();
    int e, n, dv, last;
    int ch[$];
    int du[$];
    logic [15:0] pr[$];
    for (int it = 0; it < 4; it++) begin
      do_reset();
      ready_delay = $urandom_range(0, 3);
      dv = $urandom_range(0, 3);
      n  = $urandom_range(2, 8);
      ch.delete(); du.delete(); pr.delete();
      reg_write(2'd3, 32'(dv), e);
      for (int i = 0; i < n; i++) begin
        ch.push_back($urandom_range(0, 3));
        du.push_back($urandom_range(0, 3));
        pr.push_back(16'($urandom));
        push_ev(ch[i], du[i], pr[i], e);
      end
      obs.delete();
      reg_write(2'd0, 32'd1, e);
      wait_writes(n, 2000);
      for (int i = 0; i < n; i++) check_write("rand_write", i, ch[i], pr[i]);
      for (int i = 0; i < n - 1; i++) check_gap("rand_gap", i, du[i] * (dv + 1) + 3);
      last = du[n - 1] * (dv + 1) + 10;
      repeat (last) @(negedge clk);
      expect_reg("rand_drained", 2'd1, 32'h100);
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_overflow();
    test_back_to_back();
    test_pause();
    test_push_pop_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
